// File: rtl/jk_excite_seq.sv
// Excitation sequencer for an external bank of WIDTH JK flip-flops: walks the bank to a
// requested target word and checks a shadow copy against q feedback. Build option JK_TOGGLE_EN.
module jk_excite_seq #(
  parameter int WIDTH  = 8,
  parameter int SERIAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt,
  input  logic             clr,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             jk_rst_o,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow,
  output logic             done,
  output logic             err
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] target, target_n, j_n, k_n, shadow_n, first_mask;
  logic [IW-1:0]    idx, idx_n;
  logic             clr_op, clr_op_n, jk_rst_n, done_n, err_n, rdy_n;

  // Returns {j, k} for the bits selected by m; unselected bits are left idle.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] j, k;
`ifdef JK_TOGGLE_EN
    j = (s ^ t) & m;
    k = j;
`else
    j = ~s & t & m;
    k = s & ~t & m;
`endif
    return {j, k};
  endfunction

  assign first_mask = (SERIAL != 0) ? WIDTH'(1) : {WIDTH{1'b1}};

  always_comb begin
    state_n  = state;
    target_n = target;
    shadow_n = shadow;
    idx_n    = idx;
    clr_op_n = clr_op;
    j_n      = '0;
    k_n      = '0;
    jk_rst_n = 1'b0;
    done_n   = 1'b0;
    err_n    = err;
    rdy_n    = 1'b0;
    case (state)
      INIT: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
      end
      IDLE: begin
        rdy_n = 1'b1;
        if (clr) begin
          // The clear pulse occupies the DRIVE slot so CHECK sees the bank after it cleared.
          jk_rst_n = 1'b1;
          shadow_n = '0;
          err_n    = 1'b0;
          clr_op_n = 1'b1;
          rdy_n    = 1'b0;
          state_n  = DRIVE;
        end else if (tgt_valid) begin
          target_n   = tgt;
          idx_n      = '0;
          clr_op_n   = 1'b0;
          {j_n, k_n} = excite(shadow, tgt, first_mask);
          rdy_n      = 1'b0;
          state_n    = DRIVE;
        end
      end
      DRIVE: begin
        if (clr_op || SERIAL == 0) begin
          if (!clr_op) shadow_n = target;
          state_n = CHECK;
        end else begin
          shadow_n[idx] = target[idx];
          if (idx == IW'(WIDTH - 1)) begin
            state_n = CHECK;
          end else begin
            idx_n      = idx + 1'b1;
            {j_n, k_n} = excite(shadow, target, WIDTH'(1) << idx_n);
          end
        end
      end
      CHECK: begin
        done_n  = 1'b1;
        rdy_n   = 1'b1;
        state_n = IDLE;
        if (q_fb != shadow) err_n = 1'b1;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      target    <= '0;
      shadow    <= '0;
      idx       <= '0;
      clr_op    <= 1'b0;
      j_o       <= '0;
      k_o       <= '0;
      jk_rst_o  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      tgt_ready <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      shadow    <= shadow_n;
      idx       <= idx_n;
      clr_op    <= clr_op_n;
      j_o       <= j_n;
      k_o       <= k_n;
      jk_rst_o  <= jk_rst_n;
      done      <= done_n;
      err       <= err_n;
      tgt_ready <= rdy_n;
    end
  end
endmodule
